// File: rtl/ram3_port_arbiter_if.sv
// Requester-side bus for the RAM3 port arbiter.
// Four read and two write valid/ready channels.
interface ram3_port_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic [3:0]         rd_req_valid;
  logic [4*AW-1:0]    rd_req_addr;
  logic [3:0]         rd_req_ready;
  logic [3:0]         rd_rsp_valid;
  logic [4*WIDTH-1:0] rd_rsp_data;
  logic [1:0]         wr_req_valid;
  logic [2*AW-1:0]    wr_req_addr;
  logic [2*WIDTH-1:0] wr_req_data;
  logic [1:0]         wr_req_ready;

  modport master (
    output rd_req_valid, rd_req_addr,
    output wr_req_valid, wr_req_addr,
    output wr_req_data,
    input  rd_req_ready, rd_rsp_valid,
    input  rd_rsp_data, wr_req_ready
  );

  modport slave (
    input  rd_req_valid, rd_req_addr,
    input  wr_req_valid, wr_req_addr,
    input  wr_req_data,
    output rd_req_ready, rd_rsp_valid,
    output rd_rsp_data, wr_req_ready
  );
endinterface

// File: rtl/ram3_port_arbiter.sv
// Round-robin arbiter sharing a 1W/3R RAM3
// between 4 readers and 2 writers, with RAW stall.
module ram3_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  ram3_port_arbiter_if.slave bus,
  output logic [AW-1:0]    ram_raddr_0,
  output logic [AW-1:0]    ram_raddr_1,
  output logic [AW-1:0]    ram_raddr_2,
  input  logic [WIDTH-1:0] ram_rdata_0,
  input  logic [WIDTH-1:0] ram_rdata_1,
  input  logic [WIDTH-1:0] ram_rdata_2,
  output logic             ram_wen_0,
  output logic [AW-1:0]    ram_waddr_0,
  output logic [WIDTH-1:0] ram_wdata_0
);

  logic          r_wr_ptr;
  logic [1:0]    r_rd_ptr;
  logic          r_hz_valid;
  logic [AW-1:0] r_hz_addr;
  logic [2:0]    r_slot_valid;
  logic [1:0]    r_slot_id [3];

  logic [1:0]       w_wr_gnt;
  logic             w_wsel;
  logic [AW-1:0]    w_raddr [4];
  logic [3:0]       w_blk;
  logic [3:0]       w_rd_gnt;
  logic [2:0]       w_port_v;
  logic [1:0]       w_port_id [3];
  logic [1:0]       w_last;
  logic [WIDTH-1:0] w_rdata [3];

  // Write grant: round-robin from r_wr_ptr, suppressed in reset.
  always_comb begin
    w_wr_gnt = 2'b00;
    if (rst) begin
      if (!r_wr_ptr) begin
        if (bus.wr_req_valid[0])      w_wr_gnt = 2'b01;
        else if (bus.wr_req_valid[1]) w_wr_gnt = 2'b10;
      end else begin
        if (bus.wr_req_valid[1])      w_wr_gnt = 2'b10;
        else if (bus.wr_req_valid[0]) w_wr_gnt = 2'b01;
      end
    end
    w_wsel = w_wr_gnt[1];
    ram_wen_0 = |w_wr_gnt;
    ram_waddr_0 = w_wsel ? bus.wr_req_addr[2*AW-1:AW]
                         : bus.wr_req_addr[AW-1:0];
    ram_wdata_0 = w_wsel ? bus.wr_req_data[2*WIDTH-1:WIDTH]
                         : bus.wr_req_data[WIDTH-1:0];
    bus.wr_req_ready = w_wr_gnt;
  end

  // Block reads that would see a write not yet committed in the RAM.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_raddr[i] = bus.rd_req_addr[i*AW +: AW];
      w_blk[i] = (ram_wen_0 && (w_raddr[i] == ram_waddr_0))
              || (r_hz_valid && (w_raddr[i] == r_hz_addr));
    end
  end

  // Read grant: first three eligible requesters from r_rd_ptr.
  always_comb begin
    logic [1:0] v_idx;
    logic [1:0] v_cnt;
    w_rd_gnt  = 4'b0000;
    w_port_v  = 3'b000;
    w_port_id = '{default: 2'd0};
    w_last    = r_rd_ptr;
    v_cnt     = 2'd0;
    v_idx     = 2'd0;
    for (int j = 0; j < 4; j++) begin
      v_idx = r_rd_ptr + 2'(j);
      if (rst && bus.rd_req_valid[v_idx]
          && !w_blk[v_idx] && (v_cnt != 2'd3)) begin
        w_rd_gnt[v_idx]  = 1'b1;
        w_port_v[v_cnt]  = 1'b1;
        w_port_id[v_cnt] = v_idx;
        w_last           = v_idx;
        v_cnt            = v_cnt + 2'd1;
      end
    end
    ram_raddr_0 = w_port_v[0] ? w_raddr[w_port_id[0]] : '0;
    ram_raddr_1 = w_port_v[1] ? w_raddr[w_port_id[1]] : '0;
    ram_raddr_2 = w_port_v[2] ? w_raddr[w_port_id[2]] : '0;
    bus.rd_req_ready = w_rd_gnt;
  end

  // Pointers, hazard record and response slots.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 2'd0;
      r_hz_valid   <= 1'b0;
      r_hz_addr    <= '0;
      r_slot_valid <= 3'b000;
      r_slot_id    <= '{default: 2'd0};
    end else begin
      if (ram_wen_0) r_wr_ptr <= ~w_wsel;
      if (|w_rd_gnt) r_rd_ptr <= w_last + 2'd1;
      r_hz_valid   <= ram_wen_0;
      r_hz_addr    <= ram_waddr_0;
      r_slot_valid <= w_port_v;
      r_slot_id    <= w_port_id;
    end
  end

  // Route each RAM port's data to the requester it was granted to.
  always_comb begin
    w_rdata[0] = ram_rdata_0;
    w_rdata[1] = ram_rdata_1;
    w_rdata[2] = ram_rdata_2;
    bus.rd_rsp_valid = 4'b0000;
    bus.rd_rsp_data  = '0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (rst && r_slot_valid[k] && (r_slot_id[k] == 2'(i))) begin
          bus.rd_rsp_valid[i] = 1'b1;
          bus.rd_rsp_data[i*WIDTH +: WIDTH] = w_rdata[k];
        end
      end
    end
  end

endmodule

// File: doc/ram3_port_arbiter.md
Name: ram3_port_arbiter

Overview:
- Shares one 1-write/3-read RAM3 instance between 4 read requesters and 2 write requesters.
- Uses valid/ready request handshakes and round-robin arbitration.
- Routes each read result back to its requester exactly one cycle after grant.
- Stalls reads that would race the RAM's internally delayed write, so every granted read returns coherent data.

Parameters:
- WIDTH, 32, data width; must match the RAM WIDTH.
- AW, 5, RAM address port width (RAM ADDR_WIDTH+1 bits).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-low reset.
- rd_req_valid  input  4  per-requester read request valid.
- rd_req_addr  input  4*AW  read addresses; requester i uses bits [i*AW +: AW].
- rd_req_ready  output  4  per-requester grant, combinational.
- rd_rsp_valid  output  4  read data valid for requester i.
- rd_rsp_data  output  4*WIDTH  read data; requester i uses [i*WIDTH +: WIDTH].
- wr_req_valid  input  2  write request valid.
- wr_req_addr  input  2*AW  write addresses.
- wr_req_data  input  2*WIDTH  write data.
- wr_req_ready  output  2  write grant, combinational.
- ram_raddr_0/1/2  output  AW each  to RAM read ports.
- ram_rdata_0/1/2  input  WIDTH each  from RAM read ports.
- ram_wen_0  output  1  to RAM wen_0.
- ram_waddr_0  output  AW  to RAM waddr_0.
- ram_wdata_0  output  WIDTH  to RAM wdata_0.

Behaviour:
- Reset (rst==0 at a posedge):
  - rd_rsp_valid=0, rd_req_ready=0, wr_req_ready=0, ram_wen_0=0.
  - Read pointer and write pointer = 0.
  - Hazard register cleared.
  - Grants stay 0 in every cycle where rst==0; an in-flight response slot is dropped.
- Handshake:
  - A request transfers in a cycle where valid && ready.
  - Requesters hold valid and address/data stable until the transfer.
  - ready never depends on the same requester's own ready.
  - Responses have no backpressure.
- Write arbitration:
  - Round-robin over 2 requesters, starting at wr_ptr.
  - At most one grant per cycle, driven combinationally onto ram_wen_0/waddr/wdata.
  - wr_ptr <= granted+1 (mod 2); unchanged if no grant.
- Hazard tracking:
  - The RAM commits a write one cycle after ram_wen_0.
  - hz_valid/hz_addr register the granted write address each cycle (hz_valid=0 if no grant).
  - A read is blocked when its address equals the write address granted this cycle, or equals hz_addr while hz_valid==1.
  - A blocked read keeps ready=0 and is not counted in arbitration.
  - Net effect: a read always returns data including every previously granted write.
- Read arbitration:
  - Scan the 4 requesters in order rd_ptr, rd_ptr+1, ... (mod 4).
  - Grant the first up-to-3 eligible (valid and not blocked) requesters.
  - The k-th grant in scan order drives ram_raddr_k; unused ports drive address 0.
  - rd_ptr <= last granted+1 (mod 4); unchanged if no grant.
- Response:
  - Per RAM port k, register slot_valid[k] and slot_id[k] (2 bits) at the grant edge.
  - In the next cycle, rd_rsp_valid[slot_id[k]]=1 and rd_rsp_data[slot_id[k]]=ram_rdata_k.
  - rd_rsp_data is don't-care when rd_rsp_valid is low; tests drive it to 0.
  - Latency from transfer to response = 1 cycle.
  - A requester may issue back-to-back, one request per cycle.
- Simultaneous events:
  - A same-cycle write and read to the same address: write granted, read stalled 2 cycles.
  - A read to a different address proceeds normally.
- Mid-operation reset: outstanding responses are discarded and never asserted after reset.

Test Plan:
- Reset: hold rst=0 with all valids high for 3 cycles -> all readys, rd_rsp_valid and ram_wen_0 stay 0; after release the first grants start from requester 0 (rd) and 0 (wr).
- Basic read: preload addr 3=0xAAAA0003 via RAM debug port; requester 2 reads addr 3 -> ready same cycle, rd_rsp_valid[2]=1 with data 0xAAAA0003 the next cycle.
- Round-robin read: all 4 requesters valid at distinct addresses each cycle -> cycle 1 grants {0,1,2}, cycle 2 grants {3,0,1}, cycle 3 grants {2,3,0}; each response carries its own address's preloaded value.
- Write arbitration: both writers valid continuously -> grants alternate 0,1,0,1; the RAM contents match the last written values.
- RAW hazard: writer 0 writes addr 7=0x12345678 at cycle t while reader 1 requests addr 7 from cycle t -> reader 1 is not ready in cycles t and t+1, is ready at t+2, and gets 0x12345678 at t+3. Reader 0 requesting addr 8 in cycle t is granted at t.
- Reset mid-flight: grant 3 reads, assert rst=0 on the next edge -> no rd_rsp_valid asserted; after release a new read completes normally.
